// File: rtl/sd_adc_stereo_decimator.sv
// sd_adc_stereo_decimator
//
// Stereo 1-bit sigma-delta / PWM receiver and decimator. Each channel takes a
// 1-bit pulse stream (comparator front-end or looped-back DAC pin), counts the
// ones in every frame of 2^FRAME_BITS clocks, keeps a boxcar sum over the last
// 2^WINDOW_BITS frame counts and scales that sum to a 16-bit unsigned
// offset-binary PCM sample. Full-scale input saturates to 0xFFFF rather than
// wrapping to 0.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   reset    synchronous active-high reset
//   d_l/d_r  left/right 1-bit streams, asynchronous to clk
//   q_l/q_r  left/right 16-bit unsigned PCM samples (0x8000 = centre)
//   q_valid  one-cycle strobe, high on the cycle q_l/q_r update
//
// FRAME_BITS + WINDOW_BITS must not exceed 16, and SYNC_STAGES must be 2..4.

module sd_adc_stereo_decimator #(
  parameter int FRAME_BITS  = 5,
  parameter int WINDOW_BITS = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_l,
  input  logic        d_r,
  output logic [15:0] q_l,
  output logic [15:0] q_r,
  output logic        q_valid
);

  localparam int FC_W    = FRAME_BITS + 1;
  localparam int SUM_W   = FRAME_BITS + WINDOW_BITS + 1;
  localparam int DEPTH   = 1 << WINDOW_BITS;
  localparam int SHIFT   = 16 - FRAME_BITS - WINDOW_BITS;
  localparam int PRIME_W = WINDOW_BITS + 1;

  localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(DEPTH);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(DEPTH - 1);

  logic [SYNC_STAGES-1:0] sync_l;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_l;
  logic                   s_r;

  logic [FRAME_BITS-1:0]  fcnt;
  logic                   frame_end;
  logic                   win_upd;

  logic [FC_W-1:0]        ones_l;
  logic [FC_W-1:0]        ones_r;
  logic [FC_W-1:0]        fc_l;
  logic [FC_W-1:0]        fc_r;

  logic [FC_W-1:0]        fifo_l [DEPTH];
  logic [FC_W-1:0]        fifo_r [DEPTH];
  logic [WINDOW_BITS-1:0] wptr;

  logic [SUM_W-1:0]       sum_l;
  logic [SUM_W-1:0]       sum_r;
  logic [SUM_W-1:0]       sum_next_l;
  logic [SUM_W-1:0]       sum_next_r;

  logic [PRIME_W-1:0]     prime_cnt;
  logic                   emit;

  // Scales a window sum up to 16 bits. A sum of exactly full scale lands on
  // bit 16, which is clamped to 0xFFFF instead of wrapping to zero.
  function automatic logic [15:0] scale(input logic [SUM_W-1:0] s);
    logic [16:0] wide;
    wide = 17'(s) << SHIFT;
    return wide[16] ? 16'hFFFF : wide[15:0];
  endfunction

  // Plain shift-register synchronisers; the last stage is the only copy of
  // the input that the counters ever see.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l <= '0;
      sync_r <= '0;
    end else begin
      sync_l <= {sync_l[SYNC_STAGES-2:0], d_l};
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_r};
    end
  end

  assign s_l = sync_l[SYNC_STAGES-1];
  assign s_r = sync_r[SYNC_STAGES-1];

  // Shared frame counter. The all-ones cycle closes a frame, and win_upd
  // marks the following cycle, where the window absorbs the new count.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt    <= '0;
      win_upd <= 1'b0;
    end else begin
      fcnt    <= fcnt + 1'b1;
      win_upd <= frame_end;
    end
  end

  assign frame_end = &fcnt;

  // Per-channel ones counters. On the frame-end cycle the current sample is
  // folded into the captured count so a frame of all ones reads 2^FRAME_BITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_l <= '0;
      ones_r <= '0;
      fc_l   <= '0;
      fc_r   <= '0;
    end else if (frame_end) begin
      fc_l   <= ones_l + {{FRAME_BITS{1'b0}}, s_l};
      fc_r   <= ones_r + {{FRAME_BITS{1'b0}}, s_r};
      ones_l <= '0;
      ones_r <= '0;
    end else begin
      ones_l <= ones_l + {{FRAME_BITS{1'b0}}, s_l};
      ones_r <= ones_r + {{FRAME_BITS{1'b0}}, s_r};
    end
  end

  // The slot at wptr is the oldest frame count; it leaves the running sum on
  // the same update that overwrites it with the newest count. Since the FIFO
  // is cleared to zero, the sum can never go negative.
  assign sum_next_l = sum_l + SUM_W'(fc_l) - SUM_W'(fifo_l[wptr]);
  assign sum_next_r = sum_r + SUM_W'(fc_r) - SUM_W'(fifo_r[wptr]);

  // Output fires on the update that fills the window for the first time and
  // on every update after that.
  assign emit = win_upd && (prime_cnt >= PRIME_LAST);

  // Boxcar window: circular buffer of frame counts, running sums and the
  // priming counter, which saturates once the window has been filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_l[i] <= '0;
        fifo_r[i] <= '0;
      end
      wptr      <= '0;
      sum_l     <= '0;
      sum_r     <= '0;
      prime_cnt <= '0;
    end else if (win_upd) begin
      fifo_l[wptr] <= fc_l;
      fifo_r[wptr] <= fc_r;
      wptr         <= wptr + 1'b1;
      sum_l        <= sum_next_l;
      sum_r        <= sum_next_r;
      if (prime_cnt != PRIME_FULL) begin
        prime_cnt <= prime_cnt + 1'b1;
      end
    end
  end

  // Registered outputs. The sample is scaled from the freshly computed sum so
  // the result appears two clocks after the frame end; before priming, the
  // previous sample is simply held.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_l     <= '0;
      q_r     <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= emit;
      if (emit) begin
        q_l <= scale(sum_next_l);
        q_r <= scale(sum_next_r);
      end
    end
  end

endmodule

// File: tb/tb_sd_adc_stereo_decimator.sv
// tb_sd_adc_stereo_decimator
//
// Directed self-checking bench for sd_adc_stereo_decimator with default
// parameters (32-clock frames, 32-frame window, 2 sync stages). Inputs are
// driven and outputs sampled on the falling edge of clk.

module tb_sd_adc_stereo_decimator;

  logic        clk;
  logic        reset;
  logic        d_l;
  logic        d_r;
  logic [15:0] q_l;
  logic [15:0] q_r;
  logic        q_valid;

  int checks;
  int errors;
  int phase;
  int mode_l;
  int mode_r;
  int n;

  sd_adc_stereo_decimator #(
    .FRAME_BITS (5),
    .WINDOW_BITS(5),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .d_l    (d_l),
    .d_r    (d_r),
    .q_l    (q_l),
    .q_r    (q_r),
    .q_valid(q_valid)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives both streams from the selected mode:
  // 0 = constant 0, 1 = constant 1, 2 = toggle every clock,
  // 3 = 8 ones then 24 zeros, repeating every 32 clocks.
  task automatic applyStimulus();
    case (mode_l)
      1:       d_l = 1'b1;
      2:       d_l = phase[0];
      3:       d_l = ((phase % 32) < 8);
      default: d_l = 1'b0;
    endcase
    case (mode_r)
      1:       d_r = 1'b1;
      2:       d_r = phase[0];
      3:       d_r = ((phase % 32) < 8);
      default: d_r = 1'b0;
    endcase
  endtask

  // Compares one observed value against its expected value and counts it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one clock and leaves the caller at the following falling edge
  // with fresh stimulus applied.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    phase++;
    applyStimulus();
  endtask

  // One-clock reset; returns at the falling edge of the first cycle after
  // the reset edge (cycle 0).
  task automatic applyReset();
    reset = 1'b1;
    applyStimulus();
    stepCycle();
    reset = 1'b0;
  endtask

  // Steps until q_valid is seen or the limit expires; returns clocks taken.
  task automatic waitValid(input int limit, output int cycles);
    cycles = 0;
    do begin
      stepCycle();
      cycles++;
    end while (!q_valid && cycles < limit);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    phase  = 0;
    mode_l = 0;
    mode_r = 0;
    reset  = 1'b1;
    d_l    = 1'b0;
    d_r    = 1'b0;
    @(negedge clk);

    // Silent inputs: reset state, first valid at cycle 1025, then 32-clock cadence.
    applyReset();
    checkOutput("reset q_valid", {31'b0, q_valid}, 32'd0);
    checkOutput("reset q_l", {16'b0, q_l}, 32'h0000);
    checkOutput("reset q_r", {16'b0, q_r}, 32'h0000);
    waitValid(1100, n);
    checkOutput("zero first valid cycle", n, 32'd1025);
    checkOutput("zero q_l", {16'b0, q_l}, 32'h0000);
    checkOutput("zero q_r", {16'b0, q_r}, 32'h0000);

    // Step the left input so its synchronised copy goes high exactly at the
    // start of frame 34 (cycle 1056).
    for (int i = 0; i < 29; i++) stepCycle();
    mode_l = 1;
    applyStimulus();
    waitValid(40, n);
    checkOutput("zero second valid gap", n, 32'd3);
    checkOutput("pre-ramp q_l", {16'b0, q_l}, 32'h0000);
    for (int k = 1; k <= 32; k++) begin
      waitValid(40, n);
      checkOutput($sformatf("ramp %0d period", k), n, 32'd32);
      checkOutput($sformatf("ramp %0d q_l", k), {16'b0, q_l},
                  (k < 32) ? (k * 32'h0800) : 32'h0000FFFF);
      checkOutput($sformatf("ramp %0d q_r", k), {16'b0, q_r}, 32'h0000);
    end

    // Reset on a q_valid cycle with both inputs high: reset wins, history is
    // discarded and priming restarts, with the two sync zeros excluded.
    mode_l = 1;
    mode_r = 1;
    applyReset();
    checkOutput("midreset q_valid", {31'b0, q_valid}, 32'd0);
    checkOutput("midreset q_l", {16'b0, q_l}, 32'h0000);
    checkOutput("midreset q_r", {16'b0, q_r}, 32'h0000);
    waitValid(1100, n);
    checkOutput("ones first valid cycle", n, 32'd1025);
    checkOutput("ones first q_l", {16'b0, q_l}, 32'hFF80);
    checkOutput("ones first q_r", {16'b0, q_r}, 32'hFF80);
    waitValid(40, n);
    checkOutput("ones second period", n, 32'd32);
    checkOutput("ones second q_l", {16'b0, q_l}, 32'hFFFF);
    checkOutput("ones second q_r", {16'b0, q_r}, 32'hFFFF);
    waitValid(40, n);
    checkOutput("ones third q_l", {16'b0, q_l}, 32'hFFFF);

    // Left toggles every clock (half scale), right carries 8 ones per 32
    // clocks (quarter scale).
    mode_l = 2;
    mode_r = 3;
    applyReset();
    waitValid(1100, n);
    checkOutput("mixed first valid cycle", n, 32'd1025);
    for (int k = 2; k <= 4; k++) begin
      waitValid(40, n);
      checkOutput($sformatf("mixed %0d period", k), n, 32'd32);
      checkOutput($sformatf("mixed %0d q_l", k), {16'b0, q_l}, 32'h8000);
      checkOutput($sformatf("mixed %0d q_r", k), {16'b0, q_r}, 32'h4000);
    end
    stepCycle();
    checkOutput("strobe one cycle", {31'b0, q_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
